// File: rtl/input_conditioner.sv
// input_conditioner: debounces five raw buttons into levels, press pulses and pause chords; defining PONG_INPUT_AUTOREPEAT_EN adds auto-repeat on bits 0-3
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int REPEAT_DELAY    = 3600000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic       pause_up,
    output logic       pause_down,
    output logic [1:0] chord_press
);
    localparam logic [20:0] DB_LAST = 21'(DEBOUNCE_CYCLES - 1);

    logic [4:0] meta, synced, rise, rep;
    logic [1:0] chord_prev;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 1048575 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("input_conditioner: parameter out of range");
    end

    // two-flop synchronizer for the asynchronous pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= '0;
            synced <= '0;
        end else begin
            meta   <= btn_raw;
            synced <= meta;
        end
    end

    genvar i;
    for (i = 0; i < 5; i++) begin : g_btn
        logic [20:0] cnt;
        logic        stable, flip, press;
        assign flip          = (synced[i] != stable) && (cnt == DB_LAST);
        assign rise[i]       = flip & synced[i];
        assign btn_level[i]  = stable;
        assign btn_press[i]  = press;

        // count while the synced pin disagrees with the level; adopt it once the count completes
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt    <= '0;
                stable <= 1'b0;
            end else if (synced[i] == stable) begin
                cnt <= '0;
            end else if (flip) begin
                cnt    <= '0;
                stable <= synced[i];
            end else begin
                cnt <= cnt + 21'd1;
            end
        end

        // press pulse on the debounced rise, plus any auto-repeat pulse
        always_ff @(posedge clk or posedge reset) begin
            if (reset) press <= 1'b0;
            else       press <= rise[i] | rep[i];
        end

`ifdef PONG_INPUT_AUTOREPEAT_EN
        if (i < 4) begin : g_rep
            logic [31:0] rcnt;
            logic        period, stay;
            assign stay   = stable & ~flip;
            assign rep[i] = stay && (rcnt == (period ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1)));

            // repeat timer runs only while the level stays high; first interval is the delay, then the period
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rcnt   <= '0;
                    period <= 1'b0;
                end else if (!stay) begin
                    rcnt   <= '0;
                    period <= 1'b0;
                end else if (rep[i]) begin
                    rcnt   <= '0;
                    period <= 1'b1;
                end else begin
                    rcnt <= rcnt + 32'd1;
                end
            end
        end else begin : g_norep
            assign rep[i] = 1'b0;
        end
`else
        assign rep[i] = 1'b0;
`endif
    end

    assign pause_up    = btn_level[0] & btn_level[2];
    assign pause_down  = btn_level[1] & btn_level[3];
    assign chord_press = {pause_down, pause_up} & ~chord_prev;

    // previous chord level for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) chord_prev <= '0;
        else       chord_prev <= {pause_down, pause_up};
    end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed vector bench for input_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3
module tb_input_conditioner;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] btn_raw = '0;
    logic [4:0] btn_level, btn_press;
    logic       pause_up, pause_down;
    logic [1:0] chord_press;
    int         tests = 0;
    int         fails = 0;

`ifdef PONG_INPUT_AUTOREPEAT_EN
    localparam logic AR = 1'b1;
`else
    localparam logic AR = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] raw;
        logic [4:0] lvl;
        logic [4:0] prs;
        logic       pu;
        logic       pd;
        logic [1:0] ch;
    } vec_t;

    vec_t tbl [24];

    input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .pause_up   (pause_up),
        .pause_down (pause_down),
        .chord_press(chord_press)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] raw, input logic [4:0] lvl, input logic [4:0] prs,
                                input logic pu, input logic pd, input logic [1:0] ch);
        return {raw, lvl, prs, pu, pd, ch};
    endfunction

    function automatic logic [12:0] outs();
        return {btn_level, btn_press, pause_up, pause_down, chord_press};
    endfunction

    task automatic check(input string name, input int idx, input logic [12:0] act, input logic [12:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // row r: outputs expected just after edge r, then raw applied until edge r+1
        for (int r = 0; r < 24; r++) tbl[r] = mk(5'h05, 5'h05, 5'h00, 1'b1, 1'b0, 2'b00);
        for (int r = 0; r < 6; r++)  tbl[r] = mk(5'h05, 5'h00, 5'h00, 1'b0, 1'b0, 2'b00);
        tbl[6] = mk(5'h05, 5'h05, 5'h05, 1'b1, 1'b0, 2'b01);
        for (int r = 8; r < 11; r++)  tbl[r].raw = 5'h15;
        for (int r = 16; r < 24; r++) tbl[r].raw = 5'h0A;
        tbl[16].prs = AR ? 5'h05 : 5'h00;
        tbl[19].prs = AR ? 5'h05 : 5'h00;
        tbl[22] = mk(5'h0A, 5'h0A, 5'h0A, 1'b0, 1'b1, 2'b10);
        tbl[23] = mk(5'h0A, 5'h0A, 5'h00, 1'b0, 1'b1, 2'b00);

        repeat (3) @(posedge clk);
        #2 check("reset", 0, outs(), 13'h0);
        reset = 1'b0;

        for (int r = 0; r < 24; r++) begin
            @(posedge clk);
            #2 check("vec", r, outs(), {tbl[r].lvl, tbl[r].prs, tbl[r].pu, tbl[r].pd, tbl[r].ch});
            btn_raw = tbl[r].raw;
        end

        #1 reset = 1'b1;
        #1 check("async_reset", 0, outs(), 13'h0);
        btn_raw = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) @(posedge clk);
        #1 btn_raw = 5'h02;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1 check("rst_mid", 0, outs(), 13'h0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #2 check("rst_hold", k, outs(), 13'h0);
        end
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #2 check("rst_release", k, {3'b000, btn_level, btn_press},
                     k < 6 ? 13'h0 : (k == 6 ? {3'b000, 5'h02, 5'h02} : {3'b000, 5'h02, 5'h00}));
        end

        btn_raw = 5'h18;
        for (int k = 1; k <= 38; k++) begin
            logic [4:0] el, ep;
            @(posedge clk);
            el = k < 6 ? 5'h02 : (k < 36 ? 5'h18 : 5'h00);
            ep = k == 6 ? 5'h18 : ((AR && k >= 16 && k <= 34 && (k - 16) % 3 == 0) ? 5'h08 : 5'h00);
            #2 check("hold_repeat", k, {3'b000, btn_level, btn_press}, {3'b000, el, ep});
            if (k == 30) btn_raw = 5'h00;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
